// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I ALU issue/retire controller:
// ALU function codes, major opcodes and FSM/kind enums.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ZERO  = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_COPY1 = 4'd11
  } alu_func_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_JUMP,
    K_BRANCH,
    K_ILL
  } kind_e;

  function automatic alu_func_e op_func(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_func_e f;
    unique case (f3)
      3'b000:  f = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b010:  f = ALU_SLT;
      3'b011:  f = ALU_SLTU;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate extraction (I/B/U/J),
// all sign-extended to 32 bits.
module rv32i_imm_gen (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_j_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31],
                    instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'h000};
  assign imm_j_o = {{11{instr_i[31]}}, instr_i[31],
                    instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

endmodule

// File: rtl/rv32i_alu_issue.sv
// Issue/retire controller for the external RV32I ALU:
// IDLE decodes, EXEC drives the ALU, RESP holds the result.
module rv32i_alu_issue
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [3:0]  alu_func_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  input  logic [31:0] alu_d_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic [31:0] rd_data_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        illegal_o
);

  logic [31:0] imm_i, imm_b, imm_u, imm_j;

  rv32i_imm_gen u_imm (
    .instr_i (instr_i),
    .imm_i_o (imm_i),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  logic unused_lt;
  assign unused_lt = alu_lt_i;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  alu_func_e   dec_func;
  logic [31:0] dec_op1, dec_op2;
  kind_e       dec_kind;
  logic        dec_ill;

  always_comb begin
    dec_func = ALU_ZERO;
    dec_op1  = '0;
    dec_op2  = '0;
    dec_kind = K_ALU;
    dec_ill  = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        dec_func = op_func(f3, f7[5]);
        dec_op1  = rs1_data_i;
        dec_op2  = rs2_data_i;
        dec_ill  = !(f7 == 7'h00 || (f7 == 7'h20 &&
                   (f3 == 3'b000 || f3 == 3'b101)));
      end
      opc == OPC_OP_IMM: begin
        dec_func = op_func(f3, f3 == 3'b101 && f7[5]);
        dec_op1  = rs1_data_i;
        dec_op2  = imm_i;
        dec_ill  = (f3 == 3'b001 || f3 == 3'b101) &&
                   !(f7 == 7'h00 || f7 == 7'h20);
      end
      opc == OPC_LUI: begin
        dec_func = ALU_COPY1;
        dec_op1  = imm_u;
      end
      opc == OPC_AUIPC: begin
        dec_func = ALU_ADD;
        dec_op1  = pc_i;
        dec_op2  = imm_u;
      end
      opc == OPC_JAL: begin
        dec_func = ALU_ADD;
        dec_op1  = pc_i;
        dec_op2  = imm_j;
        dec_kind = K_JUMP;
      end
      opc == OPC_JALR: begin
        dec_func = ALU_ADD;
        dec_op1  = rs1_data_i;
        dec_op2  = imm_i;
        dec_kind = K_JUMP;
      end
      opc == OPC_BRANCH: begin
        dec_op1  = rs1_data_i;
        dec_op2  = rs2_data_i;
        dec_kind = K_BRANCH;
        unique case (f3[2:1])
          2'b00:   dec_func = ALU_SUB;
          2'b10:   dec_func = ALU_SLT;
          2'b11:   dec_func = ALU_SLTU;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_func = ALU_ZERO;
      dec_op1  = '0;
      dec_op2  = '0;
      dec_kind = K_ILL;
    end
  end

  state_e      state_q, state_d;
  alu_func_e   func_q, func_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [4:0]  rd_q, rd_d;
  kind_e       kind_q, kind_d;
  logic        neg_q, neg_d;
  logic [31:0] link_q, link_d, btgt_q, btgt_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d, tgt_q, tgt_d;
  logic        taken_q, taken_d, ill_q, ill_d;

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rd_d    = rd_q;
    kind_d  = kind_q;
    neg_d   = neg_q;
    link_d  = link_q;
    btgt_d  = btgt_q;
    we_d    = we_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    taken_d = taken_q;
    ill_d   = ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          func_d  = dec_func;
          op1_d   = dec_op1;
          op2_d   = dec_op2;
          rd_d    = instr_i[11:7];
          kind_d  = dec_kind;
          // BNE/BLT/BLTU take on !zero, the rest on zero
          neg_d   = f3[0] ^ f3[2];
          link_d  = pc_i + 32'd4;
          btgt_d  = pc_i + imm_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        we_d    = (kind_q == K_ALU || kind_q == K_JUMP)
                  && rd_q != '0;
        data_d  = (kind_q == K_JUMP) ? link_q : alu_d_i;
        taken_d = (kind_q == K_JUMP) ||
                  (kind_q == K_BRANCH &&
                   (alu_zero_i ^ neg_q));
        tgt_d   = (kind_q == K_BRANCH) ? btgt_q
                  : {alu_d_i[31:1], 1'b0};
        ill_d   = kind_q == K_ILL;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      func_q  <= ALU_ZERO;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      kind_q  <= K_ALU;
      neg_q   <= 1'b0;
      link_q  <= '0;
      btgt_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      tgt_q   <= '0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      kind_q  <= kind_d;
      neg_q   <= neg_d;
      link_q  <= link_d;
      btgt_q  <= btgt_d;
      we_q    <= we_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready_o      = state_q == ST_IDLE;
  assign out_valid_o     = state_q == ST_RESP;
  assign alu_func_o      = func_q;
  assign alu_op1_o       = op1_q;
  assign alu_op2_o       = op2_q;
  assign rd_addr_o       = rd_q;
  assign rd_we_o         = we_q;
  assign rd_data_o       = data_q;
  assign branch_taken_o  = taken_q;
  assign branch_target_o = tgt_q;
  assign illegal_o       = ill_q;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Bench for rv32i_alu_issue: reference ALU, vector table,
// scoreboard, plus backpressure and mid-flight reset cases.
module tb_rv32i_alu_issue;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0;
  logic [3:0]  alu_func_o;
  logic [31:0] alu_op1_o, alu_op2_o, alu_d_i;
  logic        alu_zero_i, alu_lt_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic [31:0] rd_data_o;
  logic        branch_taken_o;
  logic [31:0] branch_target_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  rv32i_alu_issue dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .instr_i         (instr_i),
    .pc_i            (pc_i),
    .rs1_data_i      (rs1_data_i),
    .rs2_data_i      (rs2_data_i),
    .alu_func_o      (alu_func_o),
    .alu_op1_o       (alu_op1_o),
    .alu_op2_o       (alu_op2_o),
    .alu_d_i         (alu_d_i),
    .alu_zero_i      (alu_zero_i),
    .alu_lt_i        (alu_lt_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .rd_addr_o       (rd_addr_o),
    .rd_we_o         (rd_we_o),
    .rd_data_o       (rd_data_o),
    .branch_taken_o  (branch_taken_o),
    .branch_target_o (branch_target_o),
    .illegal_o       (illegal_o)
  );

  // reference ALU
  always_comb begin
    alu_d_i = '0;
    case (alu_func_o)
      4'd1:  alu_d_i = alu_op1_o + alu_op2_o;
      4'd2:  alu_d_i = alu_op1_o - alu_op2_o;
      4'd3:  alu_d_i = alu_op1_o & alu_op2_o;
      4'd4:  alu_d_i = alu_op1_o ^ alu_op2_o;
      4'd5:  alu_d_i = alu_op1_o | alu_op2_o;
      4'd6:  alu_d_i = {31'b0, $signed(alu_op1_o) < $signed(alu_op2_o)};
      4'd7:  alu_d_i = {31'b0, alu_op1_o < alu_op2_o};
      4'd8:  alu_d_i = alu_op1_o << alu_op2_o[4:0];
      4'd9:  alu_d_i = alu_op1_o >> alu_op2_o[4:0];
      4'd10: alu_d_i = $unsigned($signed(alu_op1_o) >>> alu_op2_o[4:0]);
      4'd11: alu_d_i = alu_op1_o;
      default: alu_d_i = '0;
    endcase
  end
  assign alu_zero_i = alu_d_i == '0;
  assign alu_lt_i   = alu_d_i[31];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  func;
    logic        we;
    logic [31:0] data;
    logic        taken;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];
  vec_t sb [$];
  int checks = 0;
  int errors = 0;
  int cur = 0;

  function automatic logic [31:0] r_t(input logic [6:0] f7,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm,
    input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm,
    input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h",
               cur, name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    chk("ready_idle", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    instr_i    = v.instr;
    pc_i       = v.pc;
    rs1_data_i = v.rs1;
    rs2_data_i = v.rs2;
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    instr_i    = '0;
    rs1_data_i = 32'hDEAD_BEEF;
    chk("func_n1", 32'(alu_func_o), 32'(v.func));
    chk("busy_exec", 32'(in_ready_o), 32'd0);
    if (v.func == 4'd11)
      chk("op1_lui", alu_op1_o, {v.instr[31:12], 12'h000});
  endtask

  task automatic wait_resp(output bit ok);
    int n = 0;
    while (!out_valid_o && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = out_valid_o;
    chk("latency", 32'(n), 32'd1);
  endtask

  task automatic check_fields(input vec_t v);
    chk("rd_addr", 32'(rd_addr_o), 32'(v.instr[11:7]));
    chk("rd_we", 32'(rd_we_o), 32'(v.we));
    if (v.we) chk("rd_data", rd_data_o, v.data);
    chk("taken", 32'(branch_taken_o), 32'(v.taken));
    if (v.chk_tgt) chk("target", branch_target_o, v.tgt);
    chk("illegal", 32'(illegal_o), 32'(v.ill));
  endtask

  task automatic retire();
    bit ok;
    vec_t e;
    wait_resp(ok);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (ok) check_fields(e);
    @(posedge clk);
    #1;
    chk("valid_drop", 32'(out_valid_o), 32'd0);
    chk("ready_back", 32'(in_ready_o), 32'd1);
  endtask

  task automatic chk_all_zero();
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_func", 32'(alu_func_o), 32'd0);
    chk("rst_op1", alu_op1_o, 32'd0);
    chk("rst_op2", alu_op2_o, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_rd_we", 32'(rd_we_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_taken", 32'(branch_taken_o), 32'd0);
    chk("rst_target", branch_target_o, 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{r_t(7'h00, 2, 1, 3'b000, 3), 32'h0, 32'd5,
                32'd7, 4'd1, 1, 32'd12, 0, 0, 32'h0, 0};
    tbl[1]  = '{r_t(7'h20, 2, 1, 3'b000, 4), 32'h0, 32'd5,
                32'd7, 4'd2, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0};
    tbl[2]  = '{b_t(13'h1FF8, 2, 1, 3'b100), 32'h100,
                32'hFFFF_FFFF, 32'd1, 4'd6, 0, 32'h0, 1, 1,
                32'hF8, 0};
    tbl[3]  = '{b_t(13'h1FF8, 2, 1, 3'b110), 32'h100,
                32'hFFFF_FFFF, 32'd1, 4'd7, 0, 32'h0, 0, 1,
                32'hF8, 0};
    tbl[4]  = '{i_t(12'd3, 5, 3'b000, 1, 7'h67), 32'h40,
                32'h2000, 32'h0, 4'd1, 1, 32'h44, 1, 1,
                32'h2002, 0};
    tbl[5]  = '{u_t(20'h12345, 0, 7'h37), 32'h0, 32'h0, 32'h0,
                4'd11, 0, 32'h0, 0, 0, 32'h0, 0};
    tbl[6]  = '{32'h0000_007F, 32'h0, 32'h1, 32'h2, 4'd0, 0,
                32'h0, 0, 0, 32'h0, 1};
    tbl[7]  = '{b_t(13'd16, 2, 1, 3'b000), 32'h200, 32'd9,
                32'd9, 4'd2, 0, 32'h0, 1, 1, 32'h210, 0};
    tbl[8]  = '{b_t(13'd16, 2, 1, 3'b001), 32'h200, 32'd9,
                32'd9, 4'd2, 0, 32'h0, 0, 1, 32'h210, 0};
    tbl[9]  = '{j_t(21'h800, 1), 32'h1000, 32'h0, 32'h0, 4'd1,
                1, 32'h1004, 1, 1, 32'h1800, 0};
    tbl[10] = '{u_t(20'h1, 7, 7'h17), 32'h300, 32'h0, 32'h0,
                4'd1, 1, 32'h1300, 0, 0, 32'h0, 0};
    tbl[11] = '{i_t(12'h404, 6, 3'b101, 5, 7'h13), 32'h0,
                32'h8000_0000, 32'h0, 4'd10, 1, 32'hF800_0000,
                0, 0, 32'h0, 0};
    tbl[12] = '{b_t(13'd8, 2, 1, 3'b010), 32'h0, 32'h1, 32'h1,
                4'd0, 0, 32'h0, 0, 0, 32'h0, 1};
    tbl[13] = '{r_t(7'h01, 2, 1, 3'b000, 3), 32'h0, 32'd5,
                32'd7, 4'd0, 0, 32'h0, 0, 0, 32'h0, 1};
    tbl[14] = '{r_t(7'h00, 2, 1, 3'b000, 9), 32'h0,
                32'hFFFF_FFFF, 32'd2, 4'd1, 1, 32'd1, 0, 0,
                32'h0, 0};
    tbl[15] = '{r_t(7'h00, 2, 1, 3'b011, 8), 32'h0, 32'd1,
                32'hFFFF_FFFF, 4'd7, 1, 32'd1, 0, 0, 32'h0, 0};
    tbl[16] = '{j_t(21'd4, 1), 32'hFFFF_FFFC, 32'h0, 32'h0,
                4'd1, 1, 32'h0, 1, 1, 32'h0, 0};
    tbl[17] = '{b_t(13'h1FF8, 2, 1, 3'b101), 32'h100,
                32'hFFFF_FFFF, 32'd1, 4'd6, 0, 32'h0, 0, 1,
                32'hF8, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    cur = -1;
    chk_all_zero();

    for (int i = 0; i < NV; i++) begin
      cur = i;
      issue(tbl[i]);
      retire();
    end

    // backpressure: hold RESP, try a second issue meanwhile
    cur = 100;
    out_ready_i = 1'b0;
    issue(tbl[0]);
    begin
      bit ok;
      wait_resp(ok);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_valid_i = 1'b1;
        instr_i    = tbl[1].instr;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd1;
      end
      check_fields(tbl[0]);
      chk("bp_valid", 32'(out_valid_o), 32'd1);
      chk("bp_ready", 32'(in_ready_o), 32'd0);
      chk("bp_func", 32'(alu_func_o), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    check_fields(tbl[0]);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 32'(out_valid_o), 32'd0);
    chk("bp_ready_back", 32'(in_ready_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_no_extra", 32'(out_valid_o), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // reset while in EXEC drops the transaction
    cur = 200;
    issue(tbl[4]);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb.delete();
    chk_all_zero();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("rst_no_valid", 32'(out_valid_o), 32'd0);
    end

    cur = 300;
    v = tbl[9];
    issue(v);
    retire();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_alu_issue.md
# rv32i_alu_issue

Multi-cycle issue/retire controller on the command side of the RV32I ALU. Accepts one decoded-register instruction per transaction from fetch/regfile, drives the ALU function code and operands, samples the ALU result and flags, and returns the writeback and branch decision to the core. It sits between the register-read stage and writeback/PC update in the TD1 datapath.

## Interface

Parameters:
- none; widths fixed at XLEN=32

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  instruction and operands valid
- in_ready_o  out  1  block can accept an instruction
- instr_i  in  32  instruction word
- pc_i  in  32  instruction address
- rs1_data_i  in  32  rs1 register value
- rs2_data_i  in  32  rs2 register value
- alu_func_o  out  4  ALU function code
- alu_op1_o  out  32  ALU operand 1
- alu_op2_o  out  32  ALU operand 2
- alu_d_i  in  32  ALU result (combinational from alu_*_o)
- alu_zero_i  in  1  ALU result == 0
- alu_lt_i  in  1  ALU result negative; unused, kept for interface completeness
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- rd_addr_o  out  5  destination register
- rd_we_o  out  1  write rd_data_o to rd_addr_o
- rd_data_o  out  32  writeback data
- branch_taken_o  out  1  redirect PC to branch_target_o
- branch_target_o  out  32  redirect address, bit 0 cleared
- illegal_o  out  1  unsupported encoding

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: in_ready_o=1. On in_valid_i, decode and register func/op1/op2/rd/kind/pc -> EXEC.
- EXEC: alu_*_o driven from registers; at the edge, capture alu_d_i/alu_zero_i into result regs -> RESP.
- RESP: out_valid_o=1, outputs stable; on out_ready_i -> IDLE. in_ready_o=0 in EXEC and RESP.
- Function codes: 0 zero, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 OR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 COPY_OP1. Code 12 is never issued.
- OP/OP-IMM: op1=rs1, op2=rs2 or I-imm. SUB/SRA selected by funct7[5] (OP-IMM shifts: funct7 must be 0000000/0100000). rd_data=d.
- LUI: func COPY_OP1, op1=U-imm. AUIPC: ADD, op1=pc, op2=U-imm.
- JAL: ADD pc+J-imm -> target; JALR: ADD rs1+I-imm, target=d & ~1. Both: rd_data=pc+4 (local adder), branch_taken=1.
- BRANCH: BEQ/BNE use SUB, taken on zero/!zero. BLT/BGE use SLT, BLTU/BGEU use SLTU, taken on !zero/zero. target=pc+B-imm (local adder). rd_we=0.
- rd_we_o=0 when rd=x0, for branches, and for illegal.
- Illegal (other opcodes, funct3 010/011 in BRANCH, bad funct7): func 0, illegal_o=1, rd_we_o=0, branch_taken_o=0; transaction still completes through RESP.
- All adds wrap modulo 2^32.

## Timing

- Accept at edge N (in_valid_i & in_ready_o); alu_*_o valid during cycle N+1; out_valid_o asserted from N+2.
- Minimum 3 cycles per instruction; RESP held indefinitely under backpressure with all outputs stable.
- in_valid_i ignored outside IDLE; inputs need only be stable in the accepting cycle.
- Reset: state IDLE; in_ready_o=1 the cycle after rst_i deasserts; every other output 0 (including alu_func_o, rd_*, branch_*, illegal_o). Reset in EXEC or RESP drops the transaction without out_valid_o.
- out_valid_o and illegal_o are registered, never combinational from inputs.

## Structure

- Package rv32i_pkg: alu_func_e enum (codes above), opcode localparams (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH), state enum.
- Sub-module rv32i_imm_gen: combinational I/B/U/J immediate extraction, sign-extended to 32 bits.
- ALU instantiated outside; connected only via alu_* ports.

## Test plan

- ADD x3,x1,x2 with rs1=5, rs2=7 -> alu_func_o=1 in cycle N+1; RESP: rd_addr=3, rd_we=1, rd_data=12.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 -> func 6, branch_taken=1, target=0xF8; BLTU same operands -> taken=0.
- JALR x1, 3(x5) with rs5=0x2000, pc=0x40 -> target=0x2002, rd_data=0x44, rd_we=1.
- LUI x0, 0x12345 -> func 11, op1=0x12345000, rd_we=0; opcode 0x7F -> illegal=1, rd_we=0, taken=0.
- Hold out_ready_i=0 for 5 cycles in RESP -> outputs stable, in_ready_o=0, second in_valid_i ignored.
- Assert rst_i in EXEC -> next cycle IDLE, all outputs 0, no out_valid_o for dropped instruction.
